// File: rtl/race_lights_pkg.sv
// Shared types and helpers for the race start-light sequencer: FSM state type,
// Galois LFSR feedback and lamp thermometer decode.
package race_lights_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HOLD  = 3'd2,
    GO    = 3'd3,
    FAULT = 3'd4
  } race_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Bit idx of a thermometer code with 'level' lamps lit from bit 0
  function automatic logic thermo_bit(input int unsigned idx, input int unsigned level);
    return idx < level;
  endfunction

endpackage

// File: rtl/race_lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads SEED on reset.
module race_lfsr16
  import race_lights_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        nReset,
  output logic [15:0] q
);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) q <= SEED;
    else         q <= lfsr_next(q);
  end

endmodule

// File: rtl/race_start_sequencer.sv
// Motorsport start-light sequencer: lamps light one by one, hold for a random
// delay, then lights out with green; jump starts latch a fault until Abort.
module race_start_sequencer
  import race_lights_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS   = 5,
  parameter int unsigned STEP_CYCLES  = 50,
  parameter int unsigned MIN_HOLD     = 20,
  parameter int unsigned RAND_W       = 4,
  parameter int unsigned GREEN_CYCLES = 100,
  parameter int unsigned CNT_W        = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic                  Launch,
  output logic [NUM_LIGHTS-1:0] Lights,
  output logic                  Green,
  output logic                  Fault,
  output logic                  Busy,
  output logic                  Done
);

  localparam int unsigned LIT_W = $clog2(NUM_LIGHTS + 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [LIT_W-1:0] LIT_MAX    = LIT_W'(NUM_LIGHTS);

  race_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      hold_q, hold_d, hold_sum;
  logic [LIT_W-1:0]      lit_q, lit_d;
  logic                  start_q, start_rise, launch_fault;
  logic [15:0]           lfsr_q;
  logic                  lfsr_unused;
  logic [NUM_LIGHTS-1:0] therm_first, therm_next;
  logic [NUM_LIGHTS-1:0] lights_d;
  logic                  green_d, fault_d, busy_d, done_d;

  race_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk    (Clk),
    .nReset (nReset),
    .q      (lfsr_q)
  );

  always_comb begin
    start_rise   = Start & ~start_q;
    launch_fault = Launch && (state_q == COUNT || state_q == HOLD);
    hold_sum     = CNT_W'(MIN_HOLD) + CNT_W'(lfsr_q[RAND_W-1:0]);
    lfsr_unused  = ^lfsr_q;
    therm_first  = '0;
    therm_next   = '0;
    for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
      therm_first[i] = thermo_bit(i, 32'd1);
      therm_next[i]  = thermo_bit(i, 32'(lit_q) + 32'd1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lit_d    = lit_q;
    hold_d   = hold_q;
    lights_d = Lights;
    green_d  = Green;
    fault_d  = Fault;
    done_d   = 1'b0;

    if (Abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      lit_d    = '0;
      lights_d = '0;
      green_d  = 1'b0;
      fault_d  = 1'b0;
    end else if (launch_fault) begin
      state_d  = FAULT;
      cnt_d    = '0;
      lights_d = '1;
      green_d  = 1'b0;
      fault_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_d  = COUNT;
            lit_d    = LIT_W'(1);
            cnt_d    = '0;
            lights_d = therm_first;
          end
        end

        COUNT: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            if (lit_q == LIT_MAX) begin
              // The hold length is frozen from the LFSR value seen on this edge
              state_d = HOLD;
              hold_d  = hold_sum;
            end else begin
              lit_d    = lit_q + LIT_W'(1);
              lights_d = therm_next;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt_q == hold_q - CNT_W'(1)) begin
            state_d  = GO;
            cnt_d    = '0;
            lights_d = '0;
            green_d  = 1'b1;
            done_d   = (GREEN_CYCLES == 1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        GO: begin
          if (cnt_q == GREEN_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            lit_d   = '0;
            green_d = 1'b0;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q + CNT_W'(1) == GREEN_LAST);
          end
        end

        FAULT: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d    = '0;
            lights_d = ~Lights;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          lit_d    = '0;
          lights_d = '0;
          green_d  = 1'b0;
          fault_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lit_q   <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      Lights  <= '0;
      Green   <= 1'b0;
      Fault   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lit_q   <= lit_d;
      hold_q  <= hold_d;
      start_q <= Start;
      Lights  <= lights_d;
      Green   <= green_d;
      Fault   <= fault_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

endmodule
